// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read initiator that fetches the system ID
// (word 0) and build timestamp (word 1) from a sysid slave and compares both
// against expected values, reporting sticky pass/mismatch/timeout status.
module sysid_check_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1391228168,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_WAIT_ID,
    S_REQ_TS,
    S_WAIT_TS,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_read;
  logic [31:0]      r_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_id_mm;
  logic             r_ts_mm;
  logic             r_to;
  logic [31:0]      r_id_val;
  logic [31:0]      r_ts_val;

  state_t           w_next;
  logic             w_start_acc;
  logic             w_cap_id;
  logic             w_cap_ts;
  logic             w_to_fire;
  logic             w_last;
  logic             w_in_phase;
  logic             w_id_mm_n;
  logic             w_ts_mm_n;
  logic             w_to_n;
  logic             w_pass_n;
  logic [CNT_W-1:0] w_cnt_n;

  // Next-state decode: handshake progress, data capture and per-phase timeout
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_cap_id    = 1'b0;
    w_cap_ts    = 1'b0;
    w_to_fire   = 1'b0;
    w_last      = (r_cnt == CNT_LAST);
    w_in_phase  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = S_REQ_ID;
        end
      end
      S_REQ_ID: begin
        w_in_phase = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          w_cap_id = 1'b1;
          w_next   = S_REQ_TS;
        end else if (w_last) begin
          w_to_fire = 1'b1;
          w_next    = S_FINISH;
        end else if (!avm_waitrequest) begin
          w_next = S_WAIT_ID;
        end
      end
      S_WAIT_ID: begin
        w_in_phase = 1'b1;
        if (avm_readdatavalid) begin
          w_cap_id = 1'b1;
          w_next   = S_REQ_TS;
        end else if (w_last) begin
          w_to_fire = 1'b1;
          w_next    = S_FINISH;
        end
      end
      S_REQ_TS: begin
        w_in_phase = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = S_FINISH;
        end else if (w_last) begin
          w_to_fire = 1'b1;
          w_next    = S_FINISH;
        end else if (!avm_waitrequest) begin
          w_next = S_WAIT_TS;
        end
      end
      S_WAIT_TS: begin
        w_in_phase = 1'b1;
        if (avm_readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = S_FINISH;
        end else if (w_last) begin
          w_to_fire = 1'b1;
          w_next    = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Next values of the sticky status so pass is valid alongside done
  always_comb begin
    w_id_mm_n = r_id_mm;
    w_ts_mm_n = r_ts_mm;
    w_to_n    = r_to;
    w_pass_n  = r_pass;
    w_cnt_n   = r_cnt;
    if (w_start_acc) begin
      w_id_mm_n = 1'b0;
      w_ts_mm_n = 1'b0;
      w_to_n    = 1'b0;
      w_pass_n  = 1'b0;
    end
    if (w_cap_id) w_id_mm_n = (avm_readdata != EXPECTED_ID);
    if (w_cap_ts) w_ts_mm_n = (avm_readdata != EXPECTED_TS);
    if (w_to_fire) w_to_n = 1'b1;
    if (w_next == S_FINISH) w_pass_n = ~w_id_mm_n & ~w_ts_mm_n & ~w_to_n;
    if ((w_next == S_REQ_ID || w_next == S_REQ_TS) && (w_next != r_state)) begin
      w_cnt_n = '0;
    end else if (w_in_phase) begin
      w_cnt_n = r_cnt + CNT_W'(1);
    end else if (w_start_acc) begin
      w_cnt_n = '0;
    end
  end

  // State and registered outputs, decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_read   <= 1'b0;
      r_addr   <= BASE_ADDR;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_id_mm  <= 1'b0;
      r_ts_mm  <= 1'b0;
      r_to     <= 1'b0;
      r_id_val <= '0;
      r_ts_val <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_n;
      r_read  <= (w_next == S_REQ_ID) || (w_next == S_REQ_TS);
      r_addr  <= (w_next == S_REQ_TS) ? TS_ADDR : BASE_ADDR;
      r_busy  <= (w_next != S_IDLE) && (w_next != S_FINISH);
      r_done  <= (w_next == S_FINISH);
      r_pass  <= w_pass_n;
      r_id_mm <= w_id_mm_n;
      r_ts_mm <= w_ts_mm_n;
      r_to    <= w_to_n;
      if (w_cap_id) r_id_val <= avm_readdata;
      if (w_cap_ts) r_ts_val <= avm_readdata;
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign timeout     = r_to;
  assign id_value    = r_id_val;
  assign ts_value    = r_ts_val;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master with a configurable sysid slave model.
module tb_sysid_check_master;

  localparam logic [31:0] GOOD_TS = 32'd1391228168;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  int total = 0;
  int bad   = 0;

  // slave model configuration
  int          cfg_wait = 0;
  int          cfg_lat  = 1;
  logic [31:0] cfg_id_data = 32'd0;
  logic [31:0] cfg_ts_data = GOOD_TS;
  bit          cfg_drop_id = 1'b0;
  bit          inj_valid = 1'b0;
  logic [31:0] inj_data = '0;

  logic [31:0] acc_q[$];
  int          stab_err = 0;
  int          wcnt = 0;
  bit          had_wait = 1'b0;
  logic [31:0] last_addr = '0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  sysid_check_master #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'd4) ? cfg_ts_data : cfg_id_data;
  endfunction

  // Slave model: drives waitrequest/readdata mid-cycle, logs accepted addresses
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = data_for(pend_addr);
        pend              = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
    if (inj_valid) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = inj_data;
      inj_valid         = 1'b0;
    end
    if (avm_read && !reset) begin
      if (had_wait && avm_address != last_addr) stab_err++;
      if (wcnt < cfg_wait) begin
        avm_waitrequest = 1'b1;
        wcnt++;
        had_wait  = 1'b1;
        last_addr = avm_address;
      end else begin
        acc_q.push_back(avm_address);
        wcnt     = 0;
        had_wait = 1'b0;
        if (!(cfg_drop_id && avm_address == 32'd0)) begin
          if (cfg_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = data_for(avm_address);
          end else begin
            pend      = 1'b1;
            pend_cnt  = cfg_lat;
            pend_addr = avm_address;
          end
        end
      end
    end else begin
      if (had_wait) stab_err++;
      had_wait = 1'b0;
      wcnt     = 0;
    end
  end

  // Pulse start for one cycle; returns at the negedge of cycle 1
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Cycle index (start cycle = 0) at which done is seen, -1 if never
  task automatic wait_done(output int cyc);
    int k = 1;
    while (!done && k < 300) begin
      @(negedge clock);
      k++;
    end
    cyc = done ? k : -1;
  endtask

  task automatic set_cfg(input int w, input int l, input logic [31:0] idd,
                         input logic [31:0] tsd, input bit drop);
    cfg_wait = w; cfg_lat = l; cfg_id_data = idd; cfg_ts_data = tsd; cfg_drop_id = drop;
    acc_q.delete();
    stab_err = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %0b want 0", avm_read); end
    total++; if (avm_address !== 32'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", avm_address); end
    total++; if ({busy, done, pass, id_mismatch, ts_mismatch, timeout} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %06b want 000000", {busy, done, pass, id_mismatch, ts_mismatch, timeout}); end
    total++; if ({id_value, ts_value} !== 64'd0) begin
      bad++; $display("FAIL reset_values: got %0h/%0h want 0/0", id_value, ts_value); end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    int cyc;
    set_cfg(0, 1, 32'd0, GOOD_TS, 1'b0);
    pulse_start();
    total++; if ({busy, avm_read, avm_address} !== {1'b1, 1'b1, 32'd0}) begin
      bad++; $display("FAIL nom_cycle1: got busy=%0b read=%0b addr=%0h want 1 1 0", busy, avm_read, avm_address); end
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL nom_done_cycle: got %0d want 5", cyc); end
    total++; if (pass !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL nom_pass: got pass=%0b busy=%0b want 1 0", pass, busy); end
    total++; if (id_value !== 32'd0 || ts_value !== GOOD_TS) begin
      bad++; $display("FAIL nom_values: got %0d/%0d want 0/%0d", id_value, ts_value, GOOD_TS); end
    total++; if (acc_q.size() != 2 || acc_q[0] !== 32'd0 || acc_q[1] !== 32'd4) begin
      bad++; $display("FAIL nom_addrs: got %0d reads want 2 (0,4)", acc_q.size()); end
    @(negedge clock);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL nom_done_width: got %0b want 0", done); end
  endtask

  task automatic test_waitstate();
    int cyc;
    set_cfg(3, 1, 32'd0, GOOD_TS, 1'b0);
    pulse_start();
    wait_done(cyc);
    total++; if (cyc !== 11) begin bad++; $display("FAIL ws_done_cycle: got %0d want 11", cyc); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL ws_stable: got %0d errors want 0", stab_err); end
    total++; if (acc_q.size() != 2) begin bad++; $display("FAIL ws_reads: got %0d want 2", acc_q.size()); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL ws_pass: got %0b want 1", pass); end
    @(negedge clock);
  endtask

  task automatic test_ts_mismatch();
    int cyc;
    set_cfg(0, 1, 32'd0, GOOD_TS + 32'd1, 1'b0);
    pulse_start();
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL tsm_done_cycle: got %0d want 5", cyc); end
    total++; if ({ts_mismatch, id_mismatch, pass} !== 3'b100) begin
      bad++; $display("FAIL tsm_flags: got ts=%0b id=%0b pass=%0b want 1 0 0", ts_mismatch, id_mismatch, pass); end
    total++; if (ts_value !== GOOD_TS + 32'd1) begin
      bad++; $display("FAIL tsm_value: got %0d want %0d", ts_value, GOOD_TS + 32'd1); end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int cyc;
    set_cfg(0, 1, 32'd0, GOOD_TS, 1'b1);
    pulse_start();
    wait_done(cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL to_done_cycle: got %0d want 9", cyc); end
    total++; if ({timeout, pass, avm_read} !== 3'b100) begin
      bad++; $display("FAIL to_flags: got to=%0b pass=%0b read=%0b want 1 0 0", timeout, pass, avm_read); end
    total++; if (acc_q.size() != 1 || acc_q[0] !== 32'd0) begin
      bad++; $display("FAIL to_reads: got %0d reads want 1 to addr 0", acc_q.size()); end
    total++; if (ts_value !== GOOD_TS + 32'd1) begin
      bad++; $display("FAIL to_ts_kept: got %0d want %0d", ts_value, GOOD_TS + 32'd1); end
    @(negedge clock);
    inj_data  = 32'd123;
    inj_valid = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (id_value !== 32'd0 || ts_value !== GOOD_TS + 32'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL to_late_valid: got id=%0d ts=%0d busy=%0b want 0 %0d 0", id_value, ts_value, busy, GOOD_TS + 32'd1); end
  endtask

  task automatic test_abort();
    int dcount = 0;
    set_cfg(0, 4, 32'd0, GOOD_TS, 1'b0);
    pulse_start();                       // at cycle 1
    repeat (2) @(negedge clock);         // cycle 3, WAIT_ID
    start = 1'b1;
    @(negedge clock);                    // cycle 4
    start = 1'b0;
    repeat (4) @(negedge clock);         // cycle 8, WAIT_TS
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if ({avm_read, busy, done} !== 3'b000) begin
      bad++; $display("FAIL abort_outputs: got read=%0b busy=%0b done=%0b want 0 0 0", avm_read, busy, done); end
    total++; if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b0 || id_value !== 32'd0 || ts_value !== 32'd0) begin
      bad++; $display("FAIL abort_flags: got %04b id=%0d ts=%0d want 0000 0 0", {pass, id_mismatch, ts_mismatch, timeout}, id_value, ts_value); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    total++; if (dcount !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcount); end
    total++; if (ts_value !== 32'd0) begin bad++; $display("FAIL abort_late_valid: got %0d want 0", ts_value); end
    total++; if (acc_q.size() != 2 || acc_q[0] !== 32'd0 || acc_q[1] !== 32'd4) begin
      bad++; $display("FAIL abort_second_start: got %0d reads want 2 (0,4)", acc_q.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_cfg(0, 1, 32'd5, GOOD_TS, 1'b0);
    pulse_start();
    wait_done(cyc);
    total++; if ({id_mismatch, pass} !== 2'b10 || id_value !== 32'd5) begin
      bad++; $display("FAIL b2b_first: got id_mm=%0b pass=%0b id=%0d want 1 0 5", id_mismatch, pass, id_value); end
    @(negedge clock);
    cfg_id_data = 32'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++; if ({id_mismatch, pass, busy} !== 3'b001) begin
      bad++; $display("FAIL b2b_cleared: got id_mm=%0b pass=%0b busy=%0b want 0 0 1", id_mismatch, pass, busy); end
    wait_done(cyc);
    total++; if (cyc !== 5 || pass !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got cycle=%0d pass=%0b want 5 1", cyc, pass); end
    @(negedge clock);
  endtask

  task automatic test_zero_latency();
    int cyc;
    set_cfg(0, 0, 32'd0, GOOD_TS, 1'b0);
    pulse_start();
    wait_done(cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL zl_done_cycle: got %0d want 3", cyc); end
    total++; if (pass !== 1'b1 || ts_value !== GOOD_TS || acc_q.size() != 2) begin
      bad++; $display("FAIL zl_result: got pass=%0b ts=%0d reads=%0d want 1 %0d 2", pass, ts_value, acc_q.size(), GOOD_TS); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_waitstate();
    test_ts_mismatch();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_zero_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
